// File: rtl/tcp_flow_state_rd_arbiter_if.sv
// Requester and state-table handshake bundle for the flow-state read arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface tcp_flow_state_rd_arbiter_if #(
    parameter int NUM_REQ  = 3,
    parameter int FLOWID_W = 8,
    parameter int STATE_W  = 64
);
    logic [NUM_REQ-1:0]          req_val;
    logic [NUM_REQ*FLOWID_W-1:0] req_flowid;
    logic [NUM_REQ-1:0]          req_rdy;
    logic [NUM_REQ-1:0]          resp_val;
    logic [STATE_W-1:0]          resp_data;
    logic [NUM_REQ-1:0]          resp_rdy;
    logic                        mem_rd_req_val;
    logic [FLOWID_W-1:0]         mem_rd_req_flowid;
    logic                        mem_rd_req_rdy;
    logic                        mem_rd_resp_val;
    logic [STATE_W-1:0]          mem_rd_resp_data;
    logic                        mem_rd_resp_rdy;

    modport slave (
        input  req_val, req_flowid, resp_rdy, mem_rd_req_rdy, mem_rd_resp_val, mem_rd_resp_data,
        output req_rdy, resp_val, resp_data, mem_rd_req_val, mem_rd_req_flowid, mem_rd_resp_rdy
    );

    modport master (
        output req_val, req_flowid, resp_rdy, mem_rd_req_rdy, mem_rd_resp_val, mem_rd_resp_data,
        input  req_rdy, resp_val, resp_data, mem_rd_req_val, mem_rd_req_flowid, mem_rd_resp_rdy
    );
endinterface

// File: rtl/tcp_flow_state_rd_arbiter.sv
// Round-robin arbiter sharing one flow-state read port between NUM_REQ requesters;
// a tag FIFO remembers who issued each read so in-order responses route back.
module tcp_flow_state_rd_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int FLOWID_W  = 8,
    parameter int STATE_W   = 64,
    parameter int TAG_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    tcp_flow_state_rd_arbiter_if.slave   bus,
    output logic [$clog2(TAG_DEPTH):0]   outstanding_cnt,
    output logic                         proto_err
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int AW   = $clog2(TAG_DEPTH);
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(TAG_DEPTH);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]     tag_mem_reg [TAG_DEPTH];
    logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]         cnt_reg, cnt_next;
    logic                proto_err_reg;

    logic [ID_W-1:0]     cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]  cand_val;
    logic [FLOWID_W-1:0] flowid_arr [NUM_REQ];
    logic [ID_W-1:0]     win_idx;
    logic                win_val;
    logic [ID_W-1:0]     head_tag;
    logic                empty, full, can_issue, push, pop;

    // Candidate gi is the requester gi positions after rr_ptr, wrapped for any NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum            = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
            assign cand_idx[gi]   = (sum >= NUM_REQ_W) ? ID_W'(sum - NUM_REQ_W) : sum[ID_W-1:0];
            assign cand_val[gi]   = bus.req_val[cand_idx[gi]];
            assign flowid_arr[gi] = bus.req_flowid[gi*FLOWID_W +: FLOWID_W];
        end
    endgenerate

    always_comb begin
        win_idx = '0;
        win_val = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_val[k]) begin
                win_idx = cand_idx[k];
                win_val = 1'b1;
            end
        end
    end

    assign empty     = (cnt_reg == '0);
    assign full      = (cnt_reg == DEPTH_W);
    assign head_tag  = tag_mem_reg[rd_ptr_reg];
    assign can_issue = win_val && !full && !rst;
    assign push      = can_issue && bus.mem_rd_req_rdy;
    assign pop       = bus.mem_rd_resp_val && bus.mem_rd_resp_rdy;

    assign bus.mem_rd_req_val    = can_issue;
    assign bus.mem_rd_req_flowid = win_val ? flowid_arr[win_idx] : '0;
    assign bus.mem_rd_resp_rdy   = !empty && !rst && bus.resp_rdy[head_tag];
    assign bus.resp_data         = bus.mem_rd_resp_data;

    always_comb begin
        bus.req_rdy  = '0;
        bus.resp_val = '0;
        if (push) begin
            bus.req_rdy[win_idx] = 1'b1;
        end
        if (bus.mem_rd_resp_val && !empty && !rst) begin
            bus.resp_val[head_tag] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        case ({push, pop})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
        rr_ptr_next = rr_ptr_reg;
        if (push) begin
            rr_ptr_next = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            cnt_reg       <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (bus.mem_rd_resp_val && empty) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: the cleared pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_reg[wr_ptr_reg] <= win_idx;
        end
    end

    assign outstanding_cnt = cnt_reg;
    assign proto_err       = proto_err_reg;
endmodule

// File: tb/tb_tcp_flow_state_rd_arbiter.sv
// Self-checking bench for the flow-state read arbiter: directed table, corner
// sequences, then random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_tcp_flow_state_rd_arbiter;
    localparam int NREQ = 3;
    localparam int FW   = 8;
    localparam int SW   = 64;
    localparam int TD   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tcp_flow_state_rd_arbiter_if #(.NUM_REQ(NREQ), .FLOWID_W(FW), .STATE_W(SW)) bus();
    logic [2:0] outstanding_cnt;
    logic       proto_err;

    tcp_flow_state_rd_arbiter #(
        .NUM_REQ(NREQ), .FLOWID_W(FW), .STATE_W(SW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .outstanding_cnt(outstanding_cnt),
        .proto_err(proto_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { int id; logic [FW-1:0] fid; } ent_t;
    ent_t m_q[$];
    int   m_rr;
    bit   m_perr;

    logic [NREQ-1:0] e_req_rdy, e_resp_val;
    logic            e_mreq_val, e_mresp_rdy;
    logic [FW-1:0]   e_flowid;
    int              e_w;

    function automatic logic [SW-1:0] data_of(input logic [FW-1:0] f);
        return {8{f}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected combinational outputs from the queue model and current inputs.
    task automatic model_comb();
        e_w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (bus.req_val[i] && e_w < 0) e_w = i;
        end
        e_mreq_val = (e_w >= 0) && (m_q.size() < TD);
        e_flowid   = (e_w >= 0) ? bus.req_flowid[e_w*FW +: FW] : '0;
        e_req_rdy  = '0;
        if (e_mreq_val && bus.mem_rd_req_rdy) e_req_rdy[e_w] = 1'b1;
        e_resp_val  = '0;
        e_mresp_rdy = 1'b0;
        if (m_q.size() > 0) begin
            if (bus.mem_rd_resp_val) e_resp_val[m_q[0].id] = 1'b1;
            e_mresp_rdy = bus.resp_rdy[m_q[0].id];
        end
    endtask

    task automatic model_update();
        bit pop_now, push_now;
        pop_now  = bus.mem_rd_resp_val && e_mresp_rdy;
        push_now = e_mreq_val && bus.mem_rd_req_rdy;
        if (bus.mem_rd_resp_val && m_q.size() == 0) m_perr = 1'b1;
        if (pop_now) begin
            $display("t=%0t resp -> req%0d fid=%02h data=%016h", $time, m_q[0].id, m_q[0].fid,
                     bus.mem_rd_resp_data);
            void'(m_q.pop_front());
        end
        if (push_now) begin
            $display("t=%0t issue req%0d fid=%02h", $time, e_w, e_flowid);
            m_q.push_back('{e_w, e_flowid});
            m_rr = (e_w + 1) % NREQ;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rr   = 0;
        m_perr = 1'b0;
    endtask

    task automatic check_all(input string ctx);
        model_comb();
        chk({ctx, ".req_rdy"}, 64'(bus.req_rdy), 64'(e_req_rdy));
        chk({ctx, ".mem_req_val"}, 64'(bus.mem_rd_req_val), 64'(e_mreq_val));
        chk({ctx, ".mem_req_flowid"}, 64'(bus.mem_rd_req_flowid), 64'(e_flowid));
        chk({ctx, ".resp_val"}, 64'(bus.resp_val), 64'(e_resp_val));
        chk({ctx, ".mem_resp_rdy"}, 64'(bus.mem_rd_resp_rdy), 64'(e_mresp_rdy));
        chk({ctx, ".cnt"}, 64'(outstanding_cnt), 64'(m_q.size()));
        chk({ctx, ".proto_err"}, 64'(proto_err), 64'(m_perr));
        if (e_resp_val != '0) chk({ctx, ".resp_data"}, bus.resp_data, data_of(m_q[0].fid));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_mem_resp(input logic v);
        bus.mem_rd_resp_val  = v;
        bus.mem_rd_resp_data = (v && m_q.size() > 0) ? data_of(m_q[0].fid) : 64'hDEAD_BEEF_0000_0000;
    endtask

    typedef struct {
        logic [2:0] req_val;
        logic       mrdy;
        logic [2:0] exp_rdy;
        logic       exp_mval;
        logic [7:0] exp_fid;
        int         exp_cnt;
    } vec_t;
    vec_t tbl[7];

    typedef struct { logic [FW-1:0] fid; int t; } mem_ent_t;
    mem_ent_t mem_pend[$];

    logic [2:0] drain_exp [4];

    initial begin
        tbl[0] = '{3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 0};
        tbl[1] = '{3'b110, 1'b0, 3'b000, 1'b1, 8'h22, 0};
        tbl[2] = '{3'b110, 1'b1, 3'b010, 1'b1, 8'h22, 0};
        tbl[3] = '{3'b011, 1'b1, 3'b001, 1'b1, 8'h11, 1};
        tbl[4] = '{3'b101, 1'b1, 3'b100, 1'b1, 8'h33, 2};
        tbl[5] = '{3'b100, 1'b1, 3'b100, 1'b1, 8'h33, 3};
        tbl[6] = '{3'b111, 1'b1, 3'b000, 1'b0, 8'h11, 4};
        drain_exp[0] = 3'b001; drain_exp[1] = 3'b100; drain_exp[2] = 3'b100; drain_exp[3] = 3'b001;

        rst = 1'b1;
        bus.req_val = 3'b111;
        bus.req_flowid = {8'h33, 8'h22, 8'h11};
        bus.resp_rdy = 3'b111;
        bus.mem_rd_req_rdy = 1'b1;
        bus.mem_rd_resp_val = 1'b1;
        bus.mem_rd_resp_data = '0;
        model_reset();
        #3;
        chk("rst.cnt", 64'(outstanding_cnt), 64'd0);
        chk("rst.proto_err", 64'(proto_err), 64'd0);
        chk("rst.mem_req_val", 64'(bus.mem_rd_req_val), 64'd0);
        chk("rst.req_rdy", 64'(bus.req_rdy), 64'd0);
        chk("rst.resp_val", 64'(bus.resp_val), 64'd0);
        chk("rst.mem_resp_rdy", 64'(bus.mem_rd_resp_rdy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rd_resp_val = 1'b0;

        // Arbitration table, no responses returned.
        for (int r = 0; r < 7; r++) begin
            bus.req_val = tbl[r].req_val;
            bus.mem_rd_req_rdy = tbl[r].mrdy;
            #1;
            model_comb();
            chk($sformatf("tbl%0d.req_rdy", r), 64'(bus.req_rdy), 64'(tbl[r].exp_rdy));
            chk($sformatf("tbl%0d.mem_req_val", r), 64'(bus.mem_rd_req_val), 64'(tbl[r].exp_mval));
            chk($sformatf("tbl%0d.flowid", r), 64'(bus.mem_rd_req_flowid), 64'(tbl[r].exp_fid));
            chk($sformatf("tbl%0d.cnt", r), 64'(outstanding_cnt), 64'(tbl[r].exp_cnt));
            tick();
        end

        // Head-of-line stall: head tag is requester 1 and it is not ready.
        bus.req_val = 3'b000;
        for (int c = 0; c < 5; c++) begin
            bus.resp_rdy = 3'b101;
            set_mem_resp(1'b1);
            #1;
            chk($sformatf("hol%0d.mem_resp_rdy", c), 64'(bus.mem_rd_resp_rdy), 64'd0);
            chk($sformatf("hol%0d.resp_val", c), 64'(bus.resp_val), 64'(3'b010));
            chk($sformatf("hol%0d.cnt", c), 64'(outstanding_cnt), 64'd4);
            model_comb();
            tick();
        end
        // First pop while full: no push in the same cycle.
        bus.resp_rdy = 3'b111;
        bus.req_val = 3'b111;
        bus.mem_rd_req_rdy = 1'b1;
        set_mem_resp(1'b1);
        #1;
        chk("pop_full.resp_val", 64'(bus.resp_val), 64'(3'b010));
        chk("pop_full.mem_resp_rdy", 64'(bus.mem_rd_resp_rdy), 64'd1);
        chk("pop_full.resp_data", bus.resp_data, data_of(8'h22));
        chk("pop_full.mem_req_val", 64'(bus.mem_rd_req_val), 64'd0);
        chk("pop_full.req_rdy", 64'(bus.req_rdy), 64'd0);
        model_comb();
        tick();
        set_mem_resp(1'b0);
        #1;
        chk("resume.mem_req_val", 64'(bus.mem_rd_req_val), 64'd1);
        chk("resume.req_rdy", 64'(bus.req_rdy), 64'(3'b001));
        chk("resume.cnt", 64'(outstanding_cnt), 64'd3);
        model_comb();
        tick();
        bus.req_val = 3'b000;
        for (int c = 0; c < 4; c++) begin
            set_mem_resp(1'b1);
            #1;
            chk($sformatf("drain%0d.resp_val", c), 64'(bus.resp_val), 64'(drain_exp[c]));
            chk($sformatf("drain%0d.mem_resp_rdy", c), 64'(bus.mem_rd_resp_rdy), 64'd1);
            model_comb();
            tick();
        end

        // Response with nothing in flight.
        set_mem_resp(1'b1);
        #1;
        chk("perr.resp_val", 64'(bus.resp_val), 64'd0);
        chk("perr.mem_resp_rdy", 64'(bus.mem_rd_resp_rdy), 64'd0);
        chk("perr.before", 64'(proto_err), 64'd0);
        model_comb();
        tick();
        set_mem_resp(1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("perr.sticky%0d", c), 64'(proto_err), 64'd1);
            model_comb();
            tick();
        end

        // Reset with two reads in flight.
        bus.req_val = 3'b100;
        for (int c = 0; c < 2; c++) begin
            #1;
            check_all("pre_rst");
            tick();
        end
        bus.req_val = 3'b111;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.cnt", 64'(outstanding_cnt), 64'd0);
        chk("mid_rst.proto_err", 64'(proto_err), 64'd0);
        chk("mid_rst.mem_req_val", 64'(bus.mem_rd_req_val), 64'd0);
        chk("mid_rst.req_rdy", 64'(bus.req_rdy), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.req_rdy", 64'(bus.req_rdy), 64'(3'b001));
        chk("post_rst.flowid", 64'(bus.mem_rd_req_flowid), 64'h11);
        check_all("post_rst");
        tick();
        bus.req_val = 3'b000;
        set_mem_resp(1'b1);
        #1;
        chk("post_rst.resp_val", 64'(bus.resp_val), 64'(3'b001));
        check_all("post_rst_resp");
        tick();

        // Random traffic; the bench plays an in-order memory with random latency.
        begin
            int last_t;
            last_t = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bit acc, rsp;
                logic [FW-1:0] acc_fid;
                bus.req_val = 3'($urandom_range(0, 7));
                bus.req_flowid = 24'($urandom);
                bus.mem_rd_req_rdy = ($urandom_range(0, 3) != 0);
                bus.resp_rdy = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
                if (mem_pend.size() > 0 && mem_pend[0].t <= cyc) begin
                    bus.mem_rd_resp_val = 1'b1;
                    bus.mem_rd_resp_data = data_of(mem_pend[0].fid);
                end else begin
                    bus.mem_rd_resp_val = 1'b0;
                    bus.mem_rd_resp_data = {$urandom, $urandom};
                end
                #1;
                check_all("rnd");
                acc = bus.mem_rd_req_val && bus.mem_rd_req_rdy;
                acc_fid = bus.mem_rd_req_flowid;
                rsp = bus.mem_rd_resp_val && bus.mem_rd_resp_rdy;
                tick();
                if (rsp && mem_pend.size() > 0) void'(mem_pend.pop_front());
                if (acc) begin
                    int t;
                    t = cyc + 1 + $urandom_range(0, 3);
                    if (t < last_t) t = last_t;
                    last_t = t;
                    mem_pend.push_back('{acc_fid, t});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
